div_clk: RTL and testbench
==========================

DIV_CLK -- requirements
Module: div_clk

Interface
REQ-001 SHALL use reset rst, asynchronous, active-low; clock clk_ms.
REQ-002 Parameter CLK_HZ, 100_000_000, frequency of clk_ms in Hz.
REQ-003 Parameter BAUD, 9600, serial bit rate for clk_x.
REQ-004 Parameter BTN_MS, 20, debounce sample period in ms for btnclk.
REQ-005 Port clk_ms  input  1  system reference clock, all logic on its rising edge.
REQ-006 Port rst  input  1  asynchronous active-low reset.
REQ-007 Port clk_1khz  output  1  1 ms period, 50 % duty square wave.
REQ-008 Port btnclk  output  1  BTN_MS period (default 20 ms, 50 Hz), 50 % duty square wave.
REQ-009 Port clk_16x  output  1  16 x BAUD square wave (default 153600 Hz).
REQ-010 Port clk_x  output  1  BAUD square wave (default 9600 Hz), exactly clk_16x / 16.

Function
REQ-011 Every output SHALL be a registered toggle flop, never gated or combinational.
REQ-012 Half-period counts SHALL be computed at elaboration: H_MS = CLK_HZ/2000, H_BTN = CLK_HZ*BTN_MS/2000, H_16 = round(CLK_HZ/(32*BAUD)); defaults 50_000, 1_000_000, 326.
REQ-013 Each divider SHALL count 0..H-1, toggle its output and wrap to 0 on the cycle the count equals H-1.
REQ-014 Counter widths SHALL be $clog2(H) bits; no overflow past H-1 is allowed.
REQ-015 clk_x SHALL toggle on the clk_ms cycle where clk_16x toggles low-to-high for the 8th time since the last clk_x toggle (3-bit sub-counter), keeping clk_x edges aligned to clk_16x rising edges.
REQ-016 Dividers SHALL be independent and free-running; no enable input.
REQ-017 A parameter yielding H < 1 SHALL be an elaboration error.

Reset
REQ-018 While rst = 0: all counters = 0, all four outputs = 0, regardless of clk_ms.
REQ-019 After rst rises, the first output rising edge SHALL occur H clk_ms edges later (clk_1khz: 50_000th edge).
REQ-020 Reset asserted mid-period SHALL immediately force outputs low and restart phase from zero.

Configuration
REQ-021 Macro DIV_CLK_UART_EN: when defined, clk_16x/clk_x dividers are built per REQ-012/015; when undefined, clk_16x and clk_x are tied 0 and their counters are omitted; clk_1khz and btnclk are unaffected.

Structure
REQ-022 Package div_clk_pkg SHALL hold default CLK_HZ, BAUD, BTN_MS constants and a half-period helper function.
REQ-023 One sub-module div_clk_toggle (parameter HALF, ports clk, rst, tick_out) SHALL be instantiated for clk_1khz, btnclk and clk_16x.

Verification
REQ-024 rst low 10 cycles then high -> all outputs 0 during reset; clk_1khz first rises at edge 50_000, falls at 100_000.
REQ-025 Run 2_000_000 edges -> btnclk rises at 1_000_000, falls at 2_000_000; clk_1khz period exactly 100_000 edges throughout.
REQ-026 DIV_CLK_UART_EN defined -> clk_16x period 652 edges; clk_x period 10_432 edges, each clk_x edge coincident with a clk_16x rising edge.
REQ-027 Pulse rst low at edge 30_000 for 5 cycles -> outputs 0 immediately; clk_1khz next rises 50_000 edges after release.
REQ-028 DIV_CLK_UART_EN undefined -> clk_16x and clk_x held 0 for 1_000_000 edges while clk_1khz toggles normally.

Source files
------------

// File: rtl/div_clk_pkg.sv
// Shared defaults and the half-period helper for the div_clk clock dividers.
package div_clk_pkg;

    localparam int unsigned DEF_CLK_HZ = 100_000_000;
    localparam int unsigned DEF_BAUD   = 9600;
    localparam int unsigned DEF_BTN_MS = 20;

    // num/den, truncated or rounded to nearest; a zero divisor yields 0 (caught as H < 1)
    function automatic int unsigned half_period(
        input longint unsigned num,
        input longint unsigned den,
        input bit              rnd
    );
        longint unsigned q;
        if (den == 64'd0) begin
            return 32'd0;
        end
        q = rnd ? (num + den / 64'd2) / den : num / den;
        return 32'(q);
    endfunction

endpackage

// File: rtl/div_clk_toggle.sv
// Free-running divider: counts 0..HALF-1 and toggles tick_out on the wrap cycle.
// wrap_c flags the cycle on which the count equals HALF-1 (the toggle cycle).
module div_clk_toggle #(
    parameter int unsigned HALF = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick_out,
    output logic wrap_c
);

    localparam int unsigned CW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    if (HALF < 1) begin : g_bad_half
        $error("div_clk_toggle: HALF must be at least 1");
    end

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    assign wrap_c   = (cnt_q == LAST);
    assign tick_out = tick_q;

    // Next count and toggle decision
    always_comb begin
        cnt_d  = cnt_q + CW'(1);
        tick_d = tick_q;
        if (wrap_c) begin
            cnt_d  = '0;
            tick_d = ~tick_q;
        end
    end

    // Counter and toggle flop, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

endmodule

// File: rtl/div_clk.sv
// Clock divider bank: 1 kHz tick, button-debounce sample clock and, when
// DIV_CLK_UART_EN is defined, the 16x baud and baud clocks. Without the
// macro clk_16x and clk_x are tied low and their counters are not built.
module div_clk
    import div_clk_pkg::*;
#(
    parameter int unsigned CLK_HZ = DEF_CLK_HZ,
    parameter int unsigned BAUD   = DEF_BAUD,
    parameter int unsigned BTN_MS = DEF_BTN_MS
) (
    input  logic clk_ms,
    input  logic rst,
    output logic clk_1khz,
    output logic btnclk,
    output logic clk_16x,
    output logic clk_x
);

    localparam int unsigned H_MS  = half_period(64'(CLK_HZ), 64'd2000, 1'b0);
    localparam int unsigned H_BTN = half_period(64'(CLK_HZ) * 64'(BTN_MS), 64'd2000, 1'b0);

    logic wrap_ms;
    logic wrap_btn;
    logic unused_wrap;

    assign unused_wrap = ^{wrap_ms, wrap_btn};

    div_clk_toggle #(.HALF(H_MS)) u_ms (
        .clk      (clk_ms),
        .rst      (rst),
        .tick_out (clk_1khz),
        .wrap_c   (wrap_ms)
    );

    div_clk_toggle #(.HALF(H_BTN)) u_btn (
        .clk      (clk_ms),
        .rst      (rst),
        .tick_out (btnclk),
        .wrap_c   (wrap_btn)
    );

`ifdef DIV_CLK_UART_EN
    localparam int unsigned H_16 = half_period(64'(CLK_HZ), 64'd32 * 64'(BAUD), 1'b1);

    logic       wrap_16;
    logic       rise_16_c;
    logic [2:0] sub_q, sub_d;
    logic       clk_x_q, clk_x_d;

    div_clk_toggle #(.HALF(H_16)) u_16x (
        .clk      (clk_ms),
        .rst      (rst),
        .tick_out (clk_16x),
        .wrap_c   (wrap_16)
    );

    // clk_16x is about to go 0->1 on this edge
    assign rise_16_c = wrap_16 & ~clk_16x;
    assign clk_x     = clk_x_q;

    // Count clk_16x rising edges; toggle clk_x on the 8th so its edges line up with them
    always_comb begin
        sub_d   = sub_q;
        clk_x_d = clk_x_q;
        if (rise_16_c) begin
            if (sub_q == 3'd7) begin
                sub_d   = 3'd0;
                clk_x_d = ~clk_x_q;
            end else begin
                sub_d = sub_q + 3'd1;
            end
        end
    end

    // Baud sub-counter and clk_x toggle flop
    always_ff @(posedge clk_ms or negedge rst) begin
        if (!rst) begin
            sub_q   <= 3'd0;
            clk_x_q <= 1'b0;
        end else begin
            sub_q   <= sub_d;
            clk_x_q <= clk_x_d;
        end
    end
`else
    localparam int unsigned UNUSED_BAUD = BAUD;

    assign clk_16x = 1'b0;
    assign clk_x   = 1'b0;
`endif

endmodule

// File: tb/tb_div_clk.sv
// Bench for div_clk at a scaled clock (1 MHz) so all periods fit a short run.
// Expected toggle edges are queued per output and popped as the DUT toggles.
module tb_div_clk;

    localparam int unsigned CLK_HZ = 1_000_000;
    localparam int unsigned BAUD   = 9600;
    localparam int unsigned BTN_MS = 20;

    // Independent reference half periods
    localparam int unsigned H_MS  = CLK_HZ / 2000;                                     // 500
    localparam int unsigned H_BTN = (CLK_HZ / 1000) * BTN_MS / 2;                      // 10_000
    localparam int unsigned H_16  = (2 * CLK_HZ + 32 * BAUD) / (2 * 32 * BAUD);        // round(3.255) = 3

    typedef struct {
        int unsigned edge_no;
        logic        lvl;
    } exp_t;

    logic clk_ms;
    logic rst;
    logic clk_1khz, btnclk, clk_16x, clk_x;
    logic [3:0] outs;
    logic [3:0] prev;
    logic       mon_en;

    int unsigned edge_n;
    int unsigned n_cmp;
    int unsigned n_err;

    exp_t  exp_q [4][$];
    string nm [4] = '{"clk_1khz", "btnclk", "clk_16x", "clk_x"};

    assign outs = {clk_x, clk_16x, btnclk, clk_1khz};

    div_clk #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD),
        .BTN_MS (BTN_MS)
    ) dut (
        .clk_ms   (clk_ms),
        .rst      (rst),
        .clk_1khz (clk_1khz),
        .btnclk   (btnclk),
        .clk_16x  (clk_16x),
        .clk_x    (clk_x)
    );

    initial clk_ms = 1'b0;
    always #5 clk_ms = ~clk_ms;

    // Rising clk_ms edges since reset release (edge 1 is the first after release)
    always @(posedge clk_ms or negedge rst) begin
        if (!rst) edge_n <= 0;
        else      edge_n <= edge_n + 1;
    end

    // Scoreboard: every observed toggle must match the next queued expectation
    always @(negedge clk_ms) begin
        if (mon_en) begin
            for (int i = 0; i < 4; i++) begin
                if (outs[i] !== prev[i]) begin
                    n_cmp++;
                    if (exp_q[i].size() == 0) begin
                        n_err++;
                        $display("FAIL %s_toggle: got toggle to %b at edge %0d, expected no toggle",
                                 nm[i], outs[i], edge_n);
                    end else begin
                        exp_t e;
                        e = exp_q[i].pop_front();
                        if (e.edge_no != edge_n || e.lvl !== outs[i]) begin
                            n_err++;
                            $display("FAIL %s_edge: got level %b at edge %0d, expected level %b at edge %0d",
                                     nm[i], outs[i], edge_n, e.lvl, e.edge_no);
                        end
                    end
`ifdef DIV_CLK_UART_EN
                    if (i == 3) begin
                        n_cmp++;
                        if (!(prev[2] === 1'b0 && outs[2] === 1'b1)) begin
                            n_err++;
                            $display("FAIL clk_x_align: got clk_16x %b->%b at edge %0d, expected 0->1",
                                     prev[2], outs[2], edge_n);
                        end
                    end
`endif
                end
            end
            prev = outs;
        end
    end

    // Queue all toggles expected within w edges after release, release reset, run w edges
    task automatic release_and_run(input int unsigned w);
        for (int i = 0; i < 4; i++) exp_q[i].delete();
        for (int unsigned k = 1; k * H_MS <= w; k++)
            exp_q[0].push_back('{k * H_MS, k[0]});
        for (int unsigned k = 1; k * H_BTN <= w; k++)
            exp_q[1].push_back('{k * H_BTN, k[0]});
`ifdef DIV_CLK_UART_EN
        for (int unsigned k = 1; k * H_16 <= w; k++)
            exp_q[2].push_back('{k * H_16, k[0]});
        for (int unsigned j = 0; (16 * j + 15) * H_16 <= w; j++)
            exp_q[3].push_back('{(16 * j + 15) * H_16, ~j[0]});
`endif
        prev   = outs;
        rst    = 1'b1;
        mon_en = 1'b1;
        repeat (w) @(negedge clk_ms);
    endtask

    task automatic test_reset;
        rst    = 1'b0;
        mon_en = 1'b0;
        repeat (10) @(negedge clk_ms);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (outs[i] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_%s: got %b, expected 0", nm[i], outs[i]);
            end
        end
    endtask

    task automatic test_dividers;
        release_and_run(2 * H_BTN + 20);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (exp_q[i].size() != 0) begin
                n_err++;
                $display("FAIL dividers_%s_missing: got %0d toggles outstanding, expected 0 (next at edge %0d)",
                         nm[i], exp_q[i].size(), exp_q[i][0].edge_no);
            end
        end
`ifndef DIV_CLK_UART_EN
        n_cmp++;
        if (outs[3:2] !== 2'b00) begin
            n_err++;
            $display("FAIL uart_off_level: got clk_x/clk_16x %b, expected 00", outs[3:2]);
        end
`endif
    endtask

    task automatic test_reset_mid;
        mon_en = 1'b0;
        rst    = 1'b0;
        repeat (2) @(negedge clk_ms);
        release_and_run(H_MS + H_MS / 2);
        n_cmp++;
        if (clk_1khz !== 1'b1) begin
            n_err++;
            $display("FAIL mid_pre_level: got clk_1khz %b, expected 1", clk_1khz);
        end
        mon_en = 1'b0;
        rst    = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (outs[i] !== 1'b0) begin
                n_err++;
                $display("FAIL mid_reset_%s: got %b, expected 0 immediately", nm[i], outs[i]);
            end
        end
        repeat (5) @(negedge clk_ms);
        release_and_run(2 * H_MS + 10);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (exp_q[i].size() != 0) begin
                n_err++;
                $display("FAIL mid_%s_missing: got %0d toggles outstanding, expected 0",
                         nm[i], exp_q[i].size());
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        mon_en = 1'b0;
        prev   = 4'b0000;
        test_reset();
        test_dividers();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
